db_lookup_client: RTL and testbench

- Request-issuing end of the key/value DB lookup interface: builds 96-bit tuple keys from parsed packet metadata and drives single-cycle key/flag/valid requests into the DB pipeline.
- Tracks outstanding requests in order, matches each DB response (out_valid/out_flag) to its packet tag, and emits a per-packet pass/drop verdict.
- Sits between the packet header parser and db_top.

---
 rtl/db_lookup_client_if.sv | 45 ++++
 rtl/db_lookup_client.sv | 126 ++++++++++++
 tb/tb_db_lookup_client.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/db_lookup_client_if.sv
// rtl/db_lookup_client_if.sv - parser request, DB request/response and verdict signals of db_lookup_client
interface db_lookup_client_if #(
   parameter int TAG_W   = 8,
   parameter int MAX_OUT = 8
);
   localparam int CNT_W = $clog2(MAX_OUT) + 1;

   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_src_ip;
   logic [31:0]      req_dst_ip;
   logic [15:0]      req_dst_port;
   logic [3:0]       req_op;
   logic [TAG_W-1:0] req_tag;

   logic [95:0]      db_key;
   logic [3:0]       db_flag;
   logic             db_valid;
   logic             db_rsp_valid;
   logic [3:0]       db_rsp_flag;

   logic             vrd_valid;
   logic [TAG_W-1:0] vrd_tag;
   logic [3:0]       vrd_flag;
   logic             vrd_drop;
   logic             vrd_timeout;
   logic [CNT_W-1:0] outstanding;
   logic [15:0]      stat_spurious;

   modport master (
      input  req_valid, req_src_ip, req_dst_ip, req_dst_port, req_op, req_tag,
      input  db_rsp_valid, db_rsp_flag,
      output req_ready, db_key, db_flag, db_valid,
      output vrd_valid, vrd_tag, vrd_flag, vrd_drop, vrd_timeout,
      output outstanding, stat_spurious
   );

   modport slave (
      output req_valid, req_src_ip, req_dst_ip, req_dst_port, req_op, req_tag,
      output db_rsp_valid, db_rsp_flag,
      input  req_ready, db_key, db_flag, db_valid,
      input  vrd_valid, vrd_tag, vrd_flag, vrd_drop, vrd_timeout,
      input  outstanding, stat_spurious
   );
endinterface

// File: rtl/db_lookup_client.sv
// rtl/db_lookup_client.sv - issues rate-limited DB lookups and turns in-order responses or timeouts into verdicts
module db_lookup_client #(
   parameter int TAG_W           = 8,
   parameter int MAX_OUT         = 8,
   parameter int ISSUE_GAP       = 3,
   parameter int TIMEOUT         = 1024,
   parameter bit DROP_ON_TIMEOUT = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   db_lookup_client_if.master   bus
);
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CNT_W = $clog2(MAX_OUT) + 1;
   localparam int GAP_W = $clog2(ISSUE_GAP + 1);

   localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUT);
   localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(ISSUE_GAP - 1);
   localparam logic [15:0]      TIMEOUT_TS = 16'(TIMEOUT);

   logic [15:0]      r_now;
   logic [TAG_W-1:0] r_fifo_tag [MAX_OUT];
   logic [15:0]      r_fifo_ts  [MAX_OUT];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_orphan;
   logic [GAP_W-1:0] r_gap;

   logic [CNT_W-1:0] w_outstanding;
   logic             w_ready;
   logic             w_accept;
   logic [15:0]      w_age;
   logic             w_fifo_nonempty;
   logic             w_orphan_rsp;
   logic             w_rsp_pop;
   logic             w_spurious;
   logic             w_expired;
   logic             w_pop;
   logic             w_drop_flag;

   // Orphans keep their slot so a late response can never be matched to a newer packet.
   assign w_outstanding   = r_count + r_orphan;
   assign w_ready         = (w_outstanding < MAX_CNT) && (r_gap == '0);
   assign w_accept        = bus.req_valid && w_ready;
   assign w_fifo_nonempty = (r_count != '0);
   assign w_age           = r_now - r_fifo_ts[r_rd_ptr];

   assign w_orphan_rsp = bus.db_rsp_valid && (r_orphan != '0);
   assign w_rsp_pop    = bus.db_rsp_valid && (r_orphan == '0) && w_fifo_nonempty;
   assign w_spurious   = bus.db_rsp_valid && (r_orphan == '0) && !w_fifo_nonempty;
   // A response arriving in the expiry cycle takes precedence over the timeout.
   assign w_expired    = w_fifo_nonempty && !bus.db_rsp_valid && (w_age >= TIMEOUT_TS);
   assign w_pop        = w_rsp_pop || w_expired;
   assign w_drop_flag  = (bus.db_rsp_flag == 4'd2) || (bus.db_rsp_flag == 4'd3);

   assign bus.req_ready   = w_ready;
   assign bus.outstanding = w_outstanding;

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_fifo_tag[r_wr_ptr] <= bus.req_tag;
         r_fifo_ts[r_wr_ptr]  <= r_now;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_now             <= '0;
         r_wr_ptr          <= '0;
         r_rd_ptr          <= '0;
         r_count           <= '0;
         r_orphan          <= '0;
         r_gap             <= '0;
         bus.db_key        <= '0;
         bus.db_flag       <= '0;
         bus.db_valid      <= 1'b0;
         bus.vrd_valid     <= 1'b0;
         bus.vrd_tag       <= '0;
         bus.vrd_flag      <= '0;
         bus.vrd_drop      <= 1'b0;
         bus.vrd_timeout   <= 1'b0;
         bus.stat_spurious <= '0;
      end else begin
         r_now        <= r_now + 16'd1;
         bus.db_valid <= w_accept;

         if (w_accept) begin
            bus.db_key  <= {bus.req_src_ip, bus.req_dst_ip, bus.req_dst_port, 16'h0000};
            bus.db_flag <= bus.req_op;
            r_gap       <= GAP_LOAD;
            r_wr_ptr    <= r_wr_ptr + 1'b1;
         end else if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
         end

         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end

         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (w_orphan_rsp) begin
            r_orphan <= r_orphan - 1'b1;
         end else if (w_expired) begin
            r_orphan <= r_orphan + 1'b1;
         end

         if (w_spurious && (bus.stat_spurious != 16'hFFFF)) begin
            bus.stat_spurious <= bus.stat_spurious + 16'd1;
         end

         bus.vrd_valid <= w_pop;
         if (w_pop) begin
            bus.vrd_tag     <= r_fifo_tag[r_rd_ptr];
            bus.vrd_flag    <= w_expired ? 4'd0 : bus.db_rsp_flag;
            bus.vrd_drop    <= w_expired ? DROP_ON_TIMEOUT : w_drop_flag;
            bus.vrd_timeout <= w_expired;
         end
      end
   end
endmodule

// File: tb/tb_db_lookup_client.sv
// tb/tb_db_lookup_client.sv - directed and random stimulus checked against a queue-based model of db_lookup_client
module tb_db_lookup_client;
   localparam int TAG_W           = 8;
   localparam int MAX_OUT         = 8;
   localparam int ISSUE_GAP       = 3;
   localparam int TIMEOUT         = 1024;
   localparam bit DROP_ON_TIMEOUT = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   db_lookup_client_if #(.TAG_W(TAG_W), .MAX_OUT(MAX_OUT)) bus ();

   db_lookup_client #(
      .TAG_W(TAG_W), .MAX_OUT(MAX_OUT), .ISSUE_GAP(ISSUE_GAP),
      .TIMEOUT(TIMEOUT), .DROP_ON_TIMEOUT(DROP_ON_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [TAG_W-1:0] tag;
      int               acc;
   } ent_t;

   ent_t             m_q[$];
   int               m_cyc      = 0;
   int               m_last_acc = -1000;
   int               m_orph     = 0;
   int               m_spur     = 0;
   logic             e_db_valid;
   logic [95:0]      e_key;
   logic [3:0]       e_flag;
   logic             e_vrd_valid;
   logic [TAG_W-1:0] e_vtag;
   logic [3:0]       e_vflag;
   logic             e_vdrop;
   logic             e_vto;

   function automatic bit m_ready();
      return (m_q.size() + m_orph < MAX_OUT) && (m_cyc - m_last_acc >= ISSUE_GAP);
   endfunction

   // Applies the spec rules for the clock edge that just happened, using the inputs held across it.
   task automatic model_edge();
      ent_t e;
      bit   acc;
      e_db_valid  = 1'b0;
      e_vrd_valid = 1'b0;
      if (rst) begin
         m_q.delete();
         m_orph     = 0;
         m_spur     = 0;
         m_last_acc = -1000;
         e_key      = '0;
         e_flag     = '0;
      end else begin
         acc = bus.req_valid && m_ready();
         if (bus.db_rsp_valid) begin
            if (m_orph > 0) begin
               m_orph--;
            end else if (m_q.size() > 0) begin
               e = m_q.pop_front();
               e_vrd_valid = 1'b1;
               e_vtag  = e.tag;
               e_vflag = bus.db_rsp_flag;
               e_vdrop = (bus.db_rsp_flag == 4'd2) || (bus.db_rsp_flag == 4'd3);
               e_vto   = 1'b0;
            end else if (m_spur < 65535) begin
               m_spur++;
            end
         end else if (m_q.size() > 0 && (m_cyc - m_q[0].acc) >= TIMEOUT) begin
            e = m_q.pop_front();
            e_vrd_valid = 1'b1;
            e_vtag  = e.tag;
            e_vflag = 4'd0;
            e_vdrop = DROP_ON_TIMEOUT;
            e_vto   = 1'b1;
            m_orph++;
         end
         if (acc) begin
            m_q.push_back('{tag: bus.req_tag, acc: m_cyc});
            m_last_acc = m_cyc;
            e_db_valid = 1'b1;
            e_key      = {bus.req_src_ip, bus.req_dst_ip, bus.req_dst_port, 16'h0000};
            e_flag     = bus.req_op;
         end
      end
      m_cyc++;
   endtask

   task automatic compare();
      check("db_valid", 96'(bus.db_valid), 96'(e_db_valid));
      check("db_key", bus.db_key, e_key);
      check("db_flag", 96'(bus.db_flag), 96'(e_flag));
      check("vrd_valid", 96'(bus.vrd_valid), 96'(e_vrd_valid));
      if (e_vrd_valid) begin
         check("vrd_tag", 96'(bus.vrd_tag), 96'(e_vtag));
         check("vrd_flag", 96'(bus.vrd_flag), 96'(e_vflag));
         check("vrd_drop", 96'(bus.vrd_drop), 96'(e_vdrop));
         check("vrd_timeout", 96'(bus.vrd_timeout), 96'(e_vto));
      end
      check("outstanding", 96'(bus.outstanding), 96'(m_q.size() + m_orph));
      check("stat_spurious", 96'(bus.stat_spurious), 96'(m_spur));
      check("req_ready", 96'(bus.req_ready), 96'(m_ready()));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
      compare();
   endtask

   task automatic idle();
      bus.req_valid    = 1'b0;
      bus.db_rsp_valid = 1'b0;
      bus.db_rsp_flag  = 4'd0;
   endtask

   task automatic set_req(input logic [31:0] s, input logic [31:0] d, input logic [15:0] p,
                          input logic [3:0] op, input logic [TAG_W-1:0] tag);
      bus.req_valid    = 1'b1;
      bus.req_src_ip   = s;
      bus.req_dst_ip   = d;
      bus.req_dst_port = p;
      bus.req_op       = op;
      bus.req_tag      = tag;
   endtask

   task automatic respond(input logic [3:0] flag);
      bus.db_rsp_valid = 1'b1;
      bus.db_rsp_flag  = flag;
      tick();
      bus.db_rsp_valid = 1'b0;
   endtask

   task automatic issue_one(input logic [TAG_W-1:0] tag);
      int budget = 20;
      set_req($urandom, $urandom, 16'($urandom), 4'($urandom), tag);
      while (!bus.req_ready && budget > 0) begin
         tick();
         budget--;
      end
      check("issue_ready_budget", 96'(budget > 0), 96'd1);
      tick();
      bus.req_valid = 1'b0;
   endtask

   logic [3:0] rsp_flags [7];

   initial begin
      bus.req_src_ip = '0; bus.req_dst_ip = '0; bus.req_dst_port = '0;
      bus.req_op = '0; bus.req_tag = '0;
      idle();
      rst = 1'b1;
      repeat (3) tick();
      check("rst_db_valid", 96'(bus.db_valid), 96'd0);
      check("rst_vrd_valid", 96'(bus.vrd_valid), 96'd0);
      check("rst_outstanding", 96'(bus.outstanding), 96'd0);
      rst = 1'b0;
      tick();
      check("rst_ready", 96'(bus.req_ready), 96'd1);

      // Single request with an ARREST response
      set_req(32'h0A000001, 32'h0A000002, 16'h1234, 4'd1, 8'd5);
      tick();
      idle();
      check("t1_db_valid", 96'(bus.db_valid), 96'd1);
      check("t1_key", bus.db_key, 96'h0A000001_0A000002_1234_0000);
      check("t1_flag", 96'(bus.db_flag), 96'd1);
      repeat (2) tick();
      respond(4'd2);
      check("t1_vrd_valid", 96'(bus.vrd_valid), 96'd1);
      check("t1_vrd_tag", 96'(bus.vrd_tag), 96'd5);
      check("t1_vrd_drop", 96'(bus.vrd_drop), 96'd1);
      tick();

      // Back-to-back requests until the window fills
      for (int i = 1; i <= 30; i++) begin
         set_req($urandom, $urandom, 16'($urandom), 4'($urandom), bus.req_ready ? 8'(m_q.size() + 1) : bus.req_tag);
         tick();
      end
      idle();
      check("full_ready", 96'(bus.req_ready), 96'd0);
      check("full_outstanding", 96'(bus.outstanding), 96'd8);
      respond(4'd0);
      check("full_first_tag", 96'(bus.vrd_tag), 96'd1);
      check("full_ready_after", 96'(bus.req_ready), 96'd1);
      rsp_flags = '{4'd1, 4'd3, 4'd4, 4'd0, 4'd2, 4'd1, 4'd0};
      for (int i = 0; i < 7; i++) begin
         tick();
         respond(rsp_flags[i]);
      end
      repeat (3) tick();

      // Timeout then a late response
      issue_one(8'h77);
      repeat (TIMEOUT + 4) tick();
      check("to_outstanding", 96'(bus.outstanding), 96'd1);
      respond(4'd1);
      check("late_no_verdict", 96'(bus.vrd_valid), 96'd0);
      check("late_outstanding", 96'(bus.outstanding), 96'd0);

      // Response exactly in the expiry cycle
      issue_one(8'h42);
      while (m_q.size() > 0 && m_cyc < m_q[0].acc + TIMEOUT) tick();
      respond(4'd1);
      check("exact_vrd_valid", 96'(bus.vrd_valid), 96'd1);
      check("exact_vrd_timeout", 96'(bus.vrd_timeout), 96'd0);
      check("exact_outstanding", 96'(bus.outstanding), 96'd0);

      // Spurious response, then reset with three outstanding
      tick();
      respond(4'd3);
      check("spurious_count", 96'(bus.stat_spurious), 96'd1);
      check("spurious_no_verdict", 96'(bus.vrd_valid), 96'd0);
      for (int i = 0; i < 3; i++) issue_one(8'(i + 20));
      check("pre_rst_outstanding", 96'(bus.outstanding), 96'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("post_rst_outstanding", 96'(bus.outstanding), 96'd0);
      check("post_rst_ready", 96'(bus.req_ready), 96'd1);
      tick();
      respond(4'd2);

      // Random traffic with response-free windows to exercise timeouts and orphans
      for (int round = 0; round < 3; round++) begin
         for (int c = 0; c < 600 + TIMEOUT + 80; c++) begin
            bus.req_valid    = ($urandom % 2) == 0;
            bus.req_src_ip   = $urandom;
            bus.req_dst_ip   = $urandom;
            bus.req_dst_port = 16'($urandom);
            bus.req_op       = 4'($urandom);
            bus.req_tag      = 8'($urandom);
            bus.db_rsp_valid = (c < 600 || c >= 600 + TIMEOUT + 40) && ($urandom % 6 == 0);
            bus.db_rsp_flag  = 4'($urandom % 5);
            rst              = ($urandom % 1500) == 0;
            tick();
         end
         rst = 1'b0;
      end
      idle();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
